// File: rtl/time_entry_loader_pkg.sv
// Shared state encodings and limits for the microwave time entry loader.
// Build option: define ENTRY_ERR_EN to reject illegal seconds-tens with err.
package time_entry_loader_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ENTRY = 2'd1,
      S_LOAD  = 2'd2,
      S_RUN   = 2'd3
   } state_t;

   localparam int MAX_DIGITS   = 3;
   localparam int SEC_TENS_MAX = 5;
   localparam int BCD_MAX      = 9;
   localparam int CNT_W        = 2;

endpackage

// File: rtl/time_entry_loader_digit_shift_reg.sv
// Three-digit keypad shift register; digits enter at d0 and move toward d2.
// Digit count saturates at MAX_DIGITS so later key presses are dropped.
module digit_shift_reg
   import time_entry_loader_pkg::*;
(
   input  logic       clk,
   input  logic       clearn,
   input  logic       i_shift,
   input  logic       i_clr,
   input  logic [3:0] i_digit,
   output logic [3:0] o_d2,
   output logic [3:0] o_d1,
   output logic [3:0] o_d0,
   output logic       o_full
);

   logic [3:0]       r_d2;
   logic [3:0]       r_d1;
   logic [3:0]       r_d0;
   logic [CNT_W-1:0] r_cnt;
   logic             w_full;

   assign w_full = (r_cnt == CNT_W'(MAX_DIGITS));

   always_ff @(posedge clk or negedge clearn) begin
      if (!clearn) begin
         r_d2  <= '0;
         r_d1  <= '0;
         r_d0  <= '0;
         r_cnt <= '0;
      end else if (i_clr) begin
         r_d2  <= '0;
         r_d1  <= '0;
         r_d0  <= '0;
         r_cnt <= '0;
      end else if (i_shift && !w_full) begin
         r_d2  <= r_d1;
         r_d1  <= r_d0;
         r_d0  <= i_digit;
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_d2   = r_d2;
   assign o_d1   = r_d1;
   assign o_d0   = r_d0;
   assign o_full = w_full;

endmodule

// File: rtl/time_entry_loader.sv
// Keypad M:SS entry, validation and load/enable sequencing for the countdown chain.
// Build option: ENTRY_ERR_EN adds err and rejects seconds-tens above SEC_TENS_MAX.
module time_entry_loader
   import time_entry_loader_pkg::*;
(
   input  logic       clk,
   input  logic       clearn,
   input  logic       digit_valid,
   input  logic [3:0] digit,
   input  logic       start_key,
   input  logic       clear_key,
   input  logic       timer_done,
   output logic [3:0] data_min,
   output logic [2:0] data_sec_tens,
   output logic [3:0] data_sec_ones,
   output logic       load_n,
`ifdef ENTRY_ERR_EN
   output logic       err,
`endif
   output logic       en,
   output logic       busy
);

   state_t     r_state;
   state_t     w_next;
   logic [3:0] w_d2;
   logic [3:0] w_d1;
   logic [3:0] w_d0;
   logic       w_full;
   logic       w_in_entry;
   logic       w_accept;
   logic       w_zero;
   logic       w_tens_bad;
   logic       w_clr;
   logic       w_load;
   logic       w_load_n_nxt;
   logic       w_en_nxt;
   logic [3:0] r_min;
   logic [2:0] r_tens;
   logic [3:0] r_ones;
   logic       r_load_n;
   logic       r_en;
   logic       r_busy;

   assign w_in_entry = (r_state == S_IDLE) || (r_state == S_ENTRY);
   assign w_accept   = w_in_entry && digit_valid && (digit <= 4'(BCD_MAX))
                       && !w_full && !start_key && !clear_key;
   assign w_zero     = ({w_d2, w_d1, w_d0} == 12'd0);
   assign w_tens_bad = (w_d1 > 4'(SEC_TENS_MAX));
   // Any return to IDLE leaves a fresh entry behind
   assign w_clr      = clear_key || ((r_state != S_IDLE) && (w_next == S_IDLE));
   assign w_load     = (w_next == S_LOAD);

   digit_shift_reg u_shift (
      .clk     (clk),
      .clearn  (clearn),
      .i_shift (w_accept),
      .i_clr   (w_clr),
      .i_digit (digit),
      .o_d2    (w_d2),
      .o_d1    (w_d1),
      .o_d0    (w_d0),
      .o_full  (w_full)
   );

   always_ff @(posedge clk or negedge clearn) begin
      if (!clearn) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (clear_key) begin
         w_next = S_IDLE;
      end else begin
         unique case (r_state)
            S_IDLE:  if (w_accept) w_next = S_ENTRY;
            S_ENTRY: begin
               if (start_key) begin
                  if (w_zero) w_next = S_IDLE;
`ifdef ENTRY_ERR_EN
                  else if (!w_tens_bad) w_next = S_LOAD;
`else
                  else w_next = S_LOAD;
`endif
               end
            end
            S_LOAD:  w_next = S_RUN;
            S_RUN:   if (timer_done) w_next = S_IDLE;
            default: w_next = S_IDLE;
         endcase
      end
   end

   // Outputs are decoded from the next state and registered to stay glitch-free
   always_comb begin
      w_load_n_nxt = !w_load;
      w_en_nxt     = (w_next == S_RUN);
   end

   always_ff @(posedge clk or negedge clearn) begin
      if (!clearn) begin
         r_load_n <= 1'b1;
         r_en     <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_load_n <= w_load_n_nxt;
         r_en     <= w_en_nxt;
         r_busy   <= w_en_nxt;
      end
   end

   always_ff @(posedge clk or negedge clearn) begin
      if (!clearn) begin
         r_min  <= '0;
         r_tens <= '0;
         r_ones <= '0;
      end else if (clear_key) begin
         r_min  <= '0;
         r_tens <= '0;
         r_ones <= '0;
      end else if (w_load) begin
         r_min  <= w_d2;
         r_tens <= w_tens_bad ? 3'(SEC_TENS_MAX) : w_d1[2:0];
         r_ones <= w_d0;
      end
   end

`ifdef ENTRY_ERR_EN
   logic r_err;
   logic w_err_nxt;

   assign w_err_nxt = !clear_key &&
      (((r_state == S_ENTRY) && start_key && !w_zero && w_tens_bad) ||
       (w_in_entry && digit_valid && (digit > 4'(BCD_MAX)) && !start_key));

   always_ff @(posedge clk or negedge clearn) begin
      if (!clearn) r_err <= 1'b0;
      else         r_err <= w_err_nxt;
   end

   assign err = r_err;
`endif

   assign data_min      = r_min;
   assign data_sec_tens = r_tens;
   assign data_sec_ones = r_ones;
   assign load_n        = r_load_n;
   assign en            = r_en;
   assign busy          = r_busy;

endmodule

// File: tb/tb_time_entry_loader.sv
// Directed scoreboard bench for time_entry_loader; expected load words are
// queued when start is pressed and checked on every observed load_n pulse.
module tb_time_entry_loader;

   logic       clk = 1'b0;
   logic       clearn = 1'b0;
   logic       digit_valid = 1'b0;
   logic [3:0] digit = '0;
   logic       start_key = 1'b0;
   logic       clear_key = 1'b0;
   logic       timer_done = 1'b0;
   logic [3:0] data_min;
   logic [2:0] data_sec_tens;
   logic [3:0] data_sec_ones;
   logic       load_n;
   logic       en;
   logic       busy;
`ifdef ENTRY_ERR_EN
   logic       err;
`endif

   typedef struct {
      int mn;
      int tn;
      int on;
   } load_t;

   load_t q[$];
   int    n_cmp = 0;
   int    n_bad = 0;
   int    n_loads = 0;

   always #5 clk = ~clk;

   time_entry_loader dut (
      .clk           (clk),
      .clearn        (clearn),
      .digit_valid   (digit_valid),
      .digit         (digit),
      .start_key     (start_key),
      .clear_key     (clear_key),
      .timer_done    (timer_done),
      .data_min      (data_min),
      .data_sec_tens (data_sec_tens),
      .data_sec_ones (data_sec_ones),
      .load_n        (load_n),
`ifdef ENTRY_ERR_EN
      .err           (err),
`endif
      .en            (en),
      .busy          (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      load_t e;
      @(posedge clk);
      #1;
      if (load_n === 1'b0) begin
         n_loads++;
         chk("load_with_en", 32'(en), 0);
         if (q.size() == 0) begin
            chk("unexpected_load", 1, 0);
         end else begin
            e = q.pop_front();
            chk("data_min", 32'(data_min), e.mn);
            chk("data_sec_tens", 32'(data_sec_tens), e.tn);
            chk("data_sec_ones", 32'(data_sec_ones), e.on);
         end
      end
   endtask

   task automatic key(input int d);
      digit_valid = 1'b1;
      digit = 4'(d);
      tick();
      digit_valid = 1'b0;
      digit = '0;
   endtask

   task automatic start_load(input int mn, input int tn, input int on);
      load_t e;
      e.mn = mn;
      e.tn = tn;
      e.on = on;
      q.push_back(e);
      start_key = 1'b1;
      tick();
      start_key = 1'b0;
      chk("load_n_low", 32'(load_n), 0);
      tick();
      chk("run_en", 32'(en), 1);
      chk("run_busy", 32'(busy), 1);
      chk("run_load_n", 32'(load_n), 1);
   endtask

   task automatic finish_run();
      timer_done = 1'b1;
      tick();
      timer_done = 1'b0;
      chk("done_en", 32'(en), 0);
      chk("done_busy", 32'(busy), 0);
   endtask

   initial begin
      tick();
      tick();
      chk("rst_load_n", 32'(load_n), 1);
      chk("rst_en", 32'(en), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_data", {data_min, data_sec_tens, data_sec_ones}, 0);
      clearn = 1'b1;
      tick();

      start_key = 1'b1;
      tick();
      start_key = 1'b0;
      tick();
      chk("idle_start_en", 32'(en), 0);

      key(1); key(3); key(0);
      start_load(1, 3, 0);
      key(4);
      chk("run_digit_en", 32'(en), 1);
      tick();
      finish_run();
      chk("hold_data_min", 32'(data_min), 1);

      start_key = 1'b1;
      tick();
      start_key = 1'b0;
      tick();
      chk("after_done_en", 32'(en), 0);

      key(2); key(4); key(5); key(7);
      start_load(2, 4, 5);
      finish_run();

      key(1); key(8); key(0);
`ifdef ENTRY_ERR_EN
      start_key = 1'b1;
      tick();
      start_key = 1'b0;
      chk("err_pulse", 32'(err), 1);
      chk("err_no_load", 32'(load_n), 1);
      tick();
      chk("err_drop", 32'(err), 0);
      start_key = 1'b1;
      tick();
      start_key = 1'b0;
      chk("err_again", 32'(err), 1);
      clear_key = 1'b1;
      tick();
      clear_key = 1'b0;
      key(12);
      chk("err_bad_digit", 32'(err), 1);
      tick();
      chk("err_clear", 32'(err), 0);
`else
      start_load(1, 5, 0);
      finish_run();
`endif

      key(0); key(0);
      start_key = 1'b1;
      tick();
      start_key = 1'b0;
      chk("zero_no_load", 32'(load_n), 1);
      key(5);
      start_load(0, 0, 5);
      finish_run();

      key(3); key(0); key(9);
      start_load(3, 0, 9);
      clear_key = 1'b1;
      timer_done = 1'b1;
      tick();
      clear_key = 1'b0;
      timer_done = 1'b0;
      chk("clr_en", 32'(en), 0);
      chk("clr_busy", 32'(busy), 0);
      chk("clr_data", {data_min, data_sec_tens, data_sec_ones}, 0);

      key(2); key(0); key(0);
      start_load(2, 0, 0);
      #2;
      clearn = 1'b0;
      #1;
      chk("async_en", 32'(en), 0);
      chk("async_busy", 32'(busy), 0);
      chk("async_load_n", 32'(load_n), 1);
      chk("async_data", {data_min, data_sec_tens, data_sec_ones}, 0);
      tick();
      clearn = 1'b1;
      tick(); tick(); tick();
      chk("post_rst_en", 32'(en), 0);

      chk("queue_empty", q.size(), 0);
`ifdef ENTRY_ERR_EN
      chk("load_count", n_loads, 5);
`else
      chk("load_count", n_loads, 6);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
